// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: queues upstream read/write commands in a small FIFO and
// issues them one at a time to an APB bridge controller, returning each result
// through a valid/ready response port.
// Optional feature: define APB_SEQ_WATCHDOG_EN to abort a transfer that sees no
// transfer_done within TIMEOUT cycles (reported with rsp_err = 1).
module apb_cmd_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    // upstream command port
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    // response port
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic [$clog2(DEPTH):0]    level,
    // APB bridge controller port
    output logic                      start_transfer,
    output logic                      write_read_n,
    output logic [ADDR_WIDTH-1:0]     address,
    output logic [DATA_WIDTH-1:0]     write_data,
    input  logic [DATA_WIDTH-1:0]     read_data,
    input  logic                      transfer_done
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    // Reject configurations the pointer arithmetic cannot handle.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("apb_cmd_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [LVL_W-1:0]      level_reg;
    state_t                state_reg;
    logic                  start_reg;
    logic                  wrn_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  rsp_valid_reg;
    logic                  rsp_write_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                  push;
    logic                  pop;

    // A full FIFO refuses pushes even when the FSM pops in the same cycle.
    assign cmd_ready = (level_reg < LVL_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_reg == IDLE) && (level_reg != '0);

    assign level          = level_reg;
    assign start_transfer = start_reg;
    assign write_read_n   = wrn_reg;
    assign address        = addr_reg;
    assign write_data     = wdata_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_write      = rsp_write_reg;
    assign rsp_rdata      = rsp_rdata_reg;

`ifdef APB_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt_reg;
    logic            rsp_err_reg;
    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    // Command storage: no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Transfer FSM: pop head in IDLE, hold bridge request in BUSY, hold response in RESP.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg     <= IDLE;
            start_reg     <= 1'b0;
            wrn_reg       <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_rdata_reg <= '0;
`ifdef APB_SEQ_WATCHDOG_EN
            wd_cnt_reg    <= '0;
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        {wrn_reg, addr_reg, wdata_reg} <= mem[rd_ptr_reg];
                        start_reg <= 1'b1;
                        state_reg <= BUSY;
`ifdef APB_SEQ_WATCHDOG_EN
                        wd_cnt_reg <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (transfer_done) begin
                        start_reg     <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_write_reg <= wrn_reg;
                        rsp_rdata_reg <= wrn_reg ? '0 : read_data;
                        state_reg     <= RESP;
`ifdef APB_SEQ_WATCHDOG_EN
                        rsp_err_reg   <= 1'b0;
                    end else if (wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
                        // The TIMEOUT-th BUSY cycle passed without completion: abort.
                        start_reg     <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_write_reg <= wrn_reg;
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        wd_cnt_reg    <= wd_cnt_reg + WD_W'(1);
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Testbench for apb_cmd_sequencer: directed commands, a bridge responder and a
// response scoreboard. Define APB_SEQ_WATCHDOG_EN to also exercise the watchdog.
module tb_apb_cmd_sequencer;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic             PCLK = 1'b0;
    logic             PRESETn = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_write = 1'b0;
    logic [AW-1:0]    cmd_addr = '0;
    logic [DW-1:0]    cmd_wdata = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic             rsp_write;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic [LVL_W-1:0] level;
    logic             start_transfer;
    logic             write_read_n;
    logic [AW-1:0]    address;
    logic [DW-1:0]    write_data;
    logic [DW-1:0]    read_data = '0;
    logic             done_drv = 1'b0;
    logic             spurious_done = 1'b0;

    apb_cmd_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .level(level),
        .start_transfer(start_transfer), .write_read_n(write_read_n),
        .address(address), .write_data(write_data),
        .read_data(read_data), .transfer_done(done_drv | spurious_done)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    // Expected bridge requests {write, addr, wdata}, responses {write, rdata, err},
    // and read data the bridge returns for each read.
    logic [64:0] exp_cmd_q[$];
    logic [33:0] exp_rsp_q[$];
    logic [31:0] rd_q[$];

    bit          bridge_en = 1'b0;
    int          bridge_delay = 2;
    bit          busy_seen = 1'b0;
    int          bcnt = 0;
    logic [64:0] cur_cmd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bridge responder: checks each request against the queue, holds it stable, completes after bridge_delay.
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            done_drv  = 1'b0;
            busy_seen = 1'b0;
            bcnt      = 0;
        end else if (done_drv) begin
            done_drv = 1'b0;
        end else if (start_transfer) begin
            if (!busy_seen) begin
                busy_seen = 1'b1;
                bcnt      = 0;
                if (exp_cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transfer: actual addr=%h required none", address);
                    cur_cmd = {write_read_n, address, write_data};
                end else begin
                    cur_cmd = exp_cmd_q.pop_front();
                end
                $display("xfer write=%0b addr=%h wdata=%h", write_read_n, address, write_data);
            end
            check("req_write", 64'(write_read_n), 64'(cur_cmd[64]));
            check("req_addr", 64'(address), 64'(cur_cmd[63:32]));
            check("req_wdata", 64'(write_data), 64'(cur_cmd[31:0]));
            bcnt++;
            if (bridge_en && bcnt > bridge_delay) begin
                done_drv  = 1'b1;
                busy_seen = 1'b0;
                if (cur_cmd[64]) begin
                    read_data = 32'hDEAD_BEEF;
                end else if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bridge_rdata: actual none required queued value");
                    read_data = '0;
                end else begin
                    read_data = rd_q.pop_front();
                end
            end
        end else begin
            busy_seen = 1'b0;
        end
    end

    // Response monitor: compares every accepted response with the scoreboard head.
    always @(negedge PCLK) begin
        if (PRESETn && rsp_valid && rsp_ready) begin
            $display("rsp write=%0b rdata=%h err=%0b", rsp_write, rsp_rdata, rsp_err);
            if (exp_rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: actual rdata=%h required none", rsp_rdata);
            end else begin
                logic [33:0] e;
                e = exp_rsp_q.pop_front();
                check("rsp_write", 64'(rsp_write), 64'(e[33]));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e[32:1]));
                check("rsp_err", 64'(rsp_err), 64'(e[0]));
            end
        end
    end

    // Offer one command; queue expectations once acceptance is certain. Returns 1 after the accepting edge.
    task automatic push_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rdata_exp, input bit err_exp);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge PCLK);
        while (!cmd_ready && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: actual cmd_ready=0 required 1");
        end else begin
            exp_cmd_q.push_back({w, a, d});
            exp_rsp_q.push_back({w, rdata_exp, err_exp});
            if (!w) rd_q.push_back(rdata_exp);
        end
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (exp_rsp_q.size() != 0 && n < max_cycles) begin
            @(negedge PCLK);
            n++;
        end
        check("drain_rsp_q", 64'(exp_rsp_q.size()), 64'd0);
        repeat (2) @(posedge PCLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_level"}, 64'(level), 64'd0);
        check({tag, "_start"}, 64'(start_transfer), 64'd0);
        check({tag, "_wrn"}, 64'(write_read_n), 64'd0);
        check({tag, "_address"}, 64'(address), 64'd0);
        check({tag, "_write_data"}, 64'(write_data), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_write"}, 64'(rsp_write), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge PCLK);
        #1;
        check_all_zero("reset");
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        // transfer_done while idle is ignored
        spurious_done = 1'b1;
        @(posedge PCLK);
        #1;
        spurious_done = 1'b0;
        check("idle_done_rsp_valid", 64'(rsp_valid), 64'd0);
        check("idle_done_start", 64'(start_transfer), 64'd0);

        // Single write: start_transfer one cycle after acceptance
        bridge_en = 1'b1;
        bridge_delay = 2;
        push_cmd(1'b1, 32'h10, 32'hA5A5_0001, 32'h0, 1'b0);
        check("wr_level_after_push", 64'(level), 64'd1);
        check("wr_start_not_yet", 64'(start_transfer), 64'd0);
        @(posedge PCLK);
        #1;
        check("wr_start", 64'(start_transfer), 64'd1);
        check("wr_address", 64'(address), 64'h10);
        check("wr_wrn", 64'(write_read_n), 64'd1);
        check("wr_level_after_pop", 64'(level), 64'd0);
        drain(100);

        // Read returning bridge data
        push_cmd(1'b0, 32'h10, 32'h0, 32'hA5A5_0001, 1'b0);
        drain(100);

        // Mixed sequence
        push_cmd(1'b1, 32'h20, 32'h1111_2222, 32'h0, 1'b0);
        push_cmd(1'b0, 32'h24, 32'h0, 32'h1234_5678, 1'b0);
        push_cmd(1'b0, 32'h28, 32'h0, 32'hCAFE_F00D, 1'b0);
        drain(200);

        // Fill: five back-to-back commands with the bridge stalled
        bridge_en = 1'b0;
        push_cmd(1'b1, 32'h100, 32'h0000_0001, 32'h0, 1'b0);
        push_cmd(1'b1, 32'h104, 32'h0000_0002, 32'h0, 1'b0);
        push_cmd(1'b0, 32'h108, 32'h0, 32'h3333_0003, 1'b0);
        push_cmd(1'b1, 32'h10C, 32'h0000_0004, 32'h0, 1'b0);
        push_cmd(1'b0, 32'h110, 32'h0, 32'h5555_0005, 1'b0);
        @(negedge PCLK);
        check("fill_cmd_ready", 64'(cmd_ready), 64'd0);
        check("fill_level", 64'(level), 64'd4);
        // A further offer while full must be refused
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'hBAD;
        cmd_wdata = 32'hBAD;
        repeat (3) @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        check("full_refuse_level", 64'(level), 64'd4);
        bridge_en = 1'b1;
        drain(400);

        // Backpressure: response held while FIFO fills
        rsp_ready = 1'b0;
        bridge_delay = 4;
        push_cmd(1'b0, 32'h40, 32'h0, 32'h0BAD_F00D, 1'b0);
        push_cmd(1'b1, 32'h44, 32'h0000_0044, 32'h0, 1'b0);
        push_cmd(1'b1, 32'h48, 32'h0000_0048, 32'h0, 1'b0);
        push_cmd(1'b1, 32'h4C, 32'h0000_004C, 32'h0, 1'b0);
        push_cmd(1'b1, 32'h50, 32'h0000_0050, 32'h0, 1'b0);
        begin
            int n = 0;
            while (!rsp_valid && n < 50) begin
                @(negedge PCLK);
                n++;
            end
        end
        check("bp_rsp_valid_seen", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_rdata", 64'(rsp_rdata), 64'h0BAD_F00D);
            check("bp_start", 64'(start_transfer), 64'd0);
            check("bp_level", 64'(level), 64'd4);
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(posedge PCLK);
        #1;
        rsp_ready = 1'b1;
        drain(400);

        // Reset mid-transfer with three commands queued
        bridge_en = 1'b0;
        push_cmd(1'b1, 32'h200, 32'h0000_0200, 32'h0, 1'b0);
        push_cmd(1'b1, 32'h204, 32'h0000_0204, 32'h0, 1'b0);
        push_cmd(1'b0, 32'h208, 32'h0, 32'h0000_0208, 1'b0);
        push_cmd(1'b1, 32'h20C, 32'h0000_020C, 32'h0, 1'b0);
        @(negedge PCLK);
        check("rst_pre_level", 64'(level), 64'd3);
        check("rst_pre_start", 64'(start_transfer), 64'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_cmd_q.delete();
        exp_rsp_q.delete();
        rd_q.delete();
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        bridge_en = 1'b1;
        repeat (10) @(posedge PCLK);
        #1;
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_rst_start", 64'(start_transfer), 64'd0);
        check("post_rst_level", 64'(level), 64'd0);

`ifdef APB_SEQ_WATCHDOG_EN
        // Watchdog: bridge never completes, abort after TIMEOUT busy cycles
        bridge_en = 1'b0;
        push_cmd(1'b1, 32'h80, 32'h0000_0055, 32'h0, 1'b1);
        begin
            int n = 0;
            int busy_cycles = 0;
            while (!start_transfer && n < 20) begin
                @(negedge PCLK);
                n++;
            end
            n = 0;
            while (start_transfer && n < 100) begin
                busy_cycles++;
                @(negedge PCLK);
                n++;
            end
            check("wd_busy_cycles", 64'(busy_cycles), 64'(TIMEOUT));
            check("wd_rsp_valid", 64'(rsp_valid), 64'd1);
            check("wd_rsp_err", 64'(rsp_err), 64'd1);
        end
        drain(100);
        bridge_en = 1'b1;
`endif

        check("final_cmd_q", 64'(exp_cmd_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_cmd_sequencer.md
APB_CMD_SEQUENCER -- requirements
Module: apb_cmd_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of the command and bridge address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of the write and read data.
REQ-003 SHALL have parameter DEPTH, default 4, number of command FIFO entries; must be a power of two and at least 2.
REQ-004 SHALL have parameter TIMEOUT, default 64, watchdog limit in PCLK cycles; used only under the configuration macro.
REQ-005 PCLK  in  1  sole clock; all state updates on the rising edge.
REQ-006 PRESETn  in  1  reset, asynchronous and active-low.
REQ-007 cmd_valid  in  1  upstream command offered.
REQ-008 cmd_ready  out  1  command FIFO can accept a command.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_WIDTH  command address.
REQ-011 cmd_wdata  in  DATA_WIDTH  command write data.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumer ready.
REQ-014 rsp_write  out  1  direction of the completed command.
REQ-015 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-016 rsp_err  out  1  transfer aborted by the watchdog.
REQ-017 level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 start_transfer, write_read_n, address[ADDR_WIDTH], write_data[DATA_WIDTH]  out  drive the APB bridge controller port.
REQ-019 read_data[DATA_WIDTH], transfer_done  in  returned by the APB bridge controller port.

Function
REQ-020 SHALL push a command on every rising edge where cmd_valid and cmd_ready are both 1; cmd_ready SHALL be 1 exactly when level < DEPTH.
REQ-021 SHALL refuse a push when the FIFO is full, even if a pop occurs in the same cycle; a simultaneous push and pop when not full SHALL leave level unchanged.
REQ-022 SHALL wrap the FIFO read and write pointers modulo DEPTH and preserve command order.
REQ-023 SHALL implement an FSM with states IDLE, BUSY and RESP.
REQ-024 In IDLE with level > 0, the FSM SHALL pop the head entry at the next edge, move to BUSY, register start_transfer = 1, and load write_read_n, address and write_data from that entry. start_transfer therefore rises one cycle after acceptance into an empty FIFO; there is no bypass path.
REQ-025 In BUSY, start_transfer, write_read_n, address and write_data SHALL stay stable until transfer_done is sampled at 1.
REQ-026 On the edge where transfer_done = 1 in BUSY, the block SHALL clear start_transfer, set rsp_valid = 1, and move to RESP.
REQ-027 On that same edge, rsp_rdata SHALL capture read_data for reads and be set to 0 for writes; rsp_write SHALL be set to the command direction.
REQ-028 transfer_done in IDLE or RESP SHALL be ignored.
REQ-029 In RESP, rsp_valid, rsp_write, rsp_rdata and rsp_err SHALL hold until rsp_ready = 1.
REQ-030 On the edge where rsp_ready = 1 in RESP, the block SHALL clear rsp_valid and return to IDLE. This guarantees at least one cycle with start_transfer low between transfers.
REQ-031 SHALL keep at most one transfer outstanding; the FIFO continues accepting commands in every state.

Reset
REQ-032 On PRESETn low, the block SHALL immediately flush the FIFO (level = 0), force the FSM to IDLE, and drive start_transfer, write_read_n, address, write_data, rsp_valid, rsp_write, rsp_rdata and rsp_err to 0. cmd_ready SHALL then be 1.
REQ-033 A reset asserted mid-transfer or mid-response SHALL discard the command in flight and every queued command, with no response issued.

Configuration
REQ-034 With macro APB_SEQ_WATCHDOG_EN defined, a cycle counter SHALL count cycles spent in BUSY. If it reaches TIMEOUT without transfer_done, the block SHALL clear start_transfer, set rsp_valid = 1, rsp_err = 1 and rsp_rdata = 0, and move to RESP. The counter SHALL clear on entry to BUSY.
REQ-035 Without APB_SEQ_WATCHDOG_EN, there SHALL be no counter, rsp_err SHALL be tied to 0, and BUSY SHALL wait indefinitely for transfer_done.

Verification
REQ-036 Single write: cmd_write=1, addr=0x10, wdata=0xA5A5_0001 -> start_transfer high the next cycle with address=0x10 and write_read_n=1. After transfer_done -> rsp_valid=1, rsp_write=1, rsp_rdata=0.
REQ-037 Read: cmd_write=0, addr=0x10; bridge returns read_data=0xA5A5_0001 with transfer_done -> rsp_rdata=0xA5A5_0001, rsp_err=0.
REQ-038 Fill: 5 back-to-back commands with DEPTH=4 while transfer_done is held low. After the 1st command is popped and the next 4 fill the FIFO -> cmd_ready=0 and level=4. Commands then complete in order 1..5.
REQ-039 Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rdata stable, start_transfer stays 0, and the FIFO still accepts until full.
REQ-040 Reset mid-transfer: PRESETn low while in BUSY with level=3 -> all outputs 0 and level=0 immediately. No response follows the release of reset.
REQ-041 With APB_SEQ_WATCHDOG_EN and TIMEOUT=8, transfer_done is never asserted -> start_transfer drops after 8 BUSY cycles, with rsp_valid=1 and rsp_err=1.
